// File: rtl/gaussian_conv.sv
// gaussian_conv: weighted kernel convolution, one normalised output pixel per window
module gaussian_conv #(
    parameter int MAX_KERNAL   = 31,
    parameter int X_MAX        = 60,
    parameter int Y_MAX        = 60,
    parameter int PIXEL_DEPTH  = 8,
    parameter int WEIGHT_DEPTH = 8
) (
    input  logic                                                    clk,
    input  logic                                                    n_rst,
    input  logic                                                    start,
    input  logic [7:0]                                              kernel_size,
    input  logic [4:0]                                              weight_shift,
    input  logic                                                    new_sample_ready,
    input  logic [MAX_KERNAL-1:0][MAX_KERNAL-1:0][PIXEL_DEPTH-1:0]  working_memory,
    output logic                                                    new_sample_req,
    output logic                                                    new_trans,
    output logic [$clog2(MAX_KERNAL)-1:0]                           weight_x,
    output logic [$clog2(MAX_KERNAL)-1:0]                           weight_y,
    input  logic [WEIGHT_DEPTH-1:0]                                 weight_rdat,
    input  logic                                                    end_pos,
    input  logic [$clog2(X_MAX)-1:0]                                curr_x,
    input  logic [$clog2(Y_MAX)-1:0]                                curr_y,
    output logic                                                    update_pos,
    output logic                                                    out_wen,
    output logic [$clog2(X_MAX):0]                                  out_x,
    output logic [$clog2(Y_MAX):0]                                  out_y,
    output logic [PIXEL_DEPTH-1:0]                                  out_wdat,
    output logic                                                    busy,
    output logic                                                    done
);
    localparam int AW   = $clog2(MAX_KERNAL);
    localparam int KW   = AW + 1;
    localparam int SW   = 2 * KW;
    localparam int ACCW = PIXEL_DEPTH + WEIGHT_DEPTH + 10;
    localparam int XW   = $clog2(X_MAX) + 1;
    localparam int YW   = $clog2(Y_MAX) + 1;

    typedef enum logic [2:0] {IDLE, INIT, WAIT, LATCH, MAC, WRITE, ADVANCE, DONE} state_t;

    state_t                 state_q, state_d;
    logic [KW-1:0]          k_q, k_d, k_clamp;
    logic [SW-1:0]          kk_q, kk_d, step_q, step_d;
    logic [AW-1:0]          wx_q, wx_d, wy_q, wy_d, dx_q, dy_q, km1;
    logic                   mac_v_q, issue;
    logic [ACCW-1:0]        acc_q, acc_d, shifted;
    logic [PIXEL_DEPTH-1:0] pix, sat, od_q, od_d;
    logic [XW-1:0]          ox_q, ox_d;
    logic [YW-1:0]          oy_q, oy_d;
    logic                   req_q, req_d, trans_q, trans_d, upd_q, upd_d;
    logic                   wen_q, wen_d, done_q, done_d;

    // Frame sequencing; the pulse outputs are registered one cycle behind their state
    always_comb begin
        state_d = state_q;
        req_d   = state_q == LATCH;
        trans_d = state_q == INIT;
        upd_d   = state_q == ADVANCE && !end_pos;
        wen_d   = state_q == WRITE;
        done_d  = state_q == DONE;
        case (state_q)
            IDLE:    state_d = start ? INIT : IDLE;
            INIT:    state_d = WAIT;
            WAIT:    state_d = new_sample_ready ? LATCH : WAIT;
            LATCH:   state_d = MAC;
            MAC:     state_d = step_q == kk_q ? WRITE : MAC;
            WRITE:   state_d = ADVANCE;
            ADVANCE: state_d = end_pos ? DONE : WAIT;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Row-major weight addressing, one-cycle-delayed pixel select and accumulation
    always_comb begin
        k_clamp = kernel_size == 8'd0 ? KW'(1) :
                  kernel_size > 8'(MAX_KERNAL) ? KW'(MAX_KERNAL) : KW'(kernel_size);
        k_d     = state_q == INIT ? k_clamp : k_q;
        kk_d    = state_q == INIT ? SW'(k_clamp) * SW'(k_clamp) : kk_q;
        km1     = AW'(k_q - KW'(1));
        issue   = state_q == MAC && step_q != kk_q;
        step_d  = state_d == LATCH ? '0 : state_q == MAC ? step_q + SW'(1) : step_q;
        wx_d    = state_d == LATCH ? '0 : !issue ? wx_q : wx_q == km1 ? '0 : wx_q + AW'(1);
        wy_d    = state_d == LATCH ? '0 : !issue || wx_q != km1 ? wy_q :
                  wy_q == km1 ? '0 : wy_q + AW'(1);
        pix     = working_memory[dx_q][dy_q];
        acc_d   = state_d == LATCH ? '0 :
                  mac_v_q ? acc_q + ACCW'(weight_rdat) * ACCW'(pix) : acc_q;
        shifted = acc_q >> weight_shift;
        sat     = |shifted[ACCW-1:PIXEL_DEPTH] ? '1 : shifted[PIXEL_DEPTH-1:0];
        od_d    = state_q == WRITE ? sat : od_q;
        ox_d    = state_q == WRITE ? XW'(curr_x) + XW'(k_q >> 1) : ox_q;
        oy_d    = state_q == WRITE ? YW'(curr_y) + YW'(k_q >> 1) : oy_q;
    end

    // State, datapath and output registers with asynchronous clear
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            kk_q    <= '0;
            step_q  <= '0;
            wx_q    <= '0;
            wy_q    <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            mac_v_q <= 1'b0;
            acc_q   <= '0;
            od_q    <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
            req_q   <= 1'b0;
            trans_q <= 1'b0;
            upd_q   <= 1'b0;
            wen_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            kk_q    <= kk_d;
            step_q  <= step_d;
            wx_q    <= wx_d;
            wy_q    <= wy_d;
            dx_q    <= wx_q;
            dy_q    <= wy_q;
            mac_v_q <= issue;
            acc_q   <= acc_d;
            od_q    <= od_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            req_q   <= req_d;
            trans_q <= trans_d;
            upd_q   <= upd_d;
            wen_q   <= wen_d;
            done_q  <= done_d;
        end
    end

    assign new_sample_req = req_q;
    assign new_trans      = trans_q;
    assign update_pos     = upd_q;
    assign out_wen        = wen_q;
    assign done           = done_q;
    assign weight_x       = wx_q;
    assign weight_y       = wy_q;
    assign out_x          = ox_q;
    assign out_y          = oy_q;
    assign out_wdat       = od_q;
    assign busy           = state_q != IDLE;
endmodule

// File: tb/tb_gaussian_conv.sv
// tb_gaussian_conv: directed frames checked against a plain-arithmetic convolution model
module tb_gaussian_conv;
    logic                    clk = 0, n_rst = 0, start = 0, new_sample_ready = 0, end_pos = 0;
    logic [7:0]              kernel_size = 0;
    logic [4:0]              weight_shift = 0;
    logic [30:0][30:0][7:0]  wm;
    logic                    new_sample_req, new_trans, update_pos, out_wen, busy, done;
    logic [4:0]              weight_x, weight_y;
    logic [7:0]              weight_rdat = 0;
    logic [5:0]              curr_x = 0, curr_y = 0;
    logic [6:0]              out_x, out_y;
    logic [7:0]              out_wdat;
    logic [7:0]              wrom [0:31][0:31];

    gaussian_conv dut (
        .clk(clk), .n_rst(n_rst), .start(start), .kernel_size(kernel_size),
        .weight_shift(weight_shift), .new_sample_ready(new_sample_ready),
        .working_memory(wm), .new_sample_req(new_sample_req), .new_trans(new_trans),
        .weight_x(weight_x), .weight_y(weight_y), .weight_rdat(weight_rdat),
        .end_pos(end_pos), .curr_x(curr_x), .curr_y(curr_y), .update_pos(update_pos),
        .out_wen(out_wen), .out_x(out_x), .out_y(out_y), .out_wdat(out_wdat),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous weight ROM: data one cycle after the address
    always @(posedge clk) weight_rdat <= wrom[weight_x][weight_y];

    typedef struct {int cyc; int d; int x; int y;} exp_t;
    exp_t q[$];
    exp_t e;
    int checks = 0, errors = 0;
    int kexp = 1, shv = 0, rdy_edge = 0;
    logic chk_lat = 0;
    int n_nt = 0, n_req = 0, n_upd = 0, n_wen = 0, n_done = 0;

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    function automatic int model(input int k, input int sh);
        longint s = 0;
        for (int y = 0; y < k; y++)
            for (int x = 0; x < k; x++)
                s += longint'(wrom[x][y]) * longint'(wm[x][y]);
        s = s >> sh;
        return s > 255 ? 255 : int'(s);
    endfunction

    // Compare process: pulse exclusivity, request latency and every written result
    always @(posedge clk) begin
        #1;
        if (n_rst) begin
            chk("pulse_exclusive", (int'(new_sample_req) + int'(new_trans) + int'(update_pos)
                + int'(out_wen) + int'(done)) > 1 ? 1 : 0, 0);
            if (new_trans) n_nt++;
            if (update_pos) n_upd++;
            if (done) n_done++;
            if (new_sample_req) begin
                n_req++;
                if (chk_lat) begin
                    chk("req_latency", cyc - rdy_edge, 1);
                    chk_lat = 0;
                end
                q.push_back('{cyc + kexp * kexp + 2, model(kexp, shv),
                              int'(curr_x) + kexp / 2, int'(curr_y) + kexp / 2});
            end
            if (out_wen) begin
                n_wen++;
                if (q.size() == 0) chk("unexpected_wen", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("wen_cycle", cyc, e.cyc);
                    chk("out_wdat", int'(out_wdat), e.d);
                    chk("out_x", int'(out_x), e.x);
                    chk("out_y", int'(out_y), e.y);
                end
            end
        end
    end

    function automatic logic sig(input int s);
        case (s)
            0: return new_sample_req;
            1: return update_pos;
            2: return done;
            3: return out_wen;
            default: return new_trans;
        endcase
    endfunction

    task automatic wait_for(input int s, input int budget, input string nm);
        int i = 0;
        logic hit = 0;
        while (!hit && i < budget) begin
            @(posedge clk);
            #1;
            hit = sig(s);
            i++;
        end
        chk({nm, "_seen"}, int'(hit), 1);
    endtask

    task automatic clr();
        n_nt = 0; n_req = 0; n_upd = 0; n_wen = 0; n_done = 0;
    endtask

    task automatic fill_const(input int p, input int w);
        for (int x = 0; x < 32; x++)
            for (int y = 0; y < 32; y++) begin
                wrom[x][y] = 8'(w);
                if (x < 31 && y < 31) wm[x][y] = 8'(p);
            end
    endtask

    task automatic fill_pattern();
        for (int x = 0; x < 32; x++)
            for (int y = 0; y < 32; y++) begin
                wrom[x][y] = 8'(x + 2 * y + 1);
                if (x < 31 && y < 31) wm[x][y] = 8'(x * 16 + y * 3 + 1);
            end
    endtask

    task automatic outputs_zero(input string nm);
        chk({nm, "_req"}, int'(new_sample_req), 0);
        chk({nm, "_trans"}, int'(new_trans), 0);
        chk({nm, "_upd"}, int'(update_pos), 0);
        chk({nm, "_wen"}, int'(out_wen), 0);
        chk({nm, "_done"}, int'(done), 0);
        chk({nm, "_busy"}, int'(busy), 0);
        chk({nm, "_wxy"}, int'({weight_x, weight_y}), 0);
        chk({nm, "_oxy"}, int'({out_x, out_y}), 0);
        chk({nm, "_wdat"}, int'(out_wdat), 0);
    endtask

    task automatic start_frame();
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        wait_for(4, 10, "new_trans");
        @(negedge clk);
        chk("busy_in_frame", int'(busy), 1);
    endtask

    task automatic window(input logic last, input int cx, input int cy);
        @(negedge clk);
        curr_x = 6'(cx);
        curr_y = 6'(cy);
        end_pos = last;
        repeat (2) @(negedge clk);
        rdy_edge = cyc + 1;
        chk_lat = 1;
        new_sample_ready = 1;
        @(negedge clk);
        new_sample_ready = 0;
        wait_for(last ? 2 : 1, 2000, last ? "done" : "update_pos");
        @(negedge clk);
        end_pos = 0;
    endtask

    task automatic run_frame(input int ksz, input int k, input int sh, input int nwin,
                             input int cx, input int cy);
        kernel_size = 8'(ksz);
        weight_shift = 5'(sh);
        kexp = k;
        shv = sh;
        clr();
        start_frame();
        for (int w = 0; w < nwin; w++) window(w == nwin - 1, cx + w, cy);
        chk("frame_new_trans", n_nt, 1);
        chk("frame_req", n_req, nwin);
        chk("frame_wen", n_wen, nwin);
        chk("frame_upd", n_upd, nwin - 1);
        chk("frame_done", n_done, 1);
        chk("frame_busy_end", int'(busy), 0);
        chk("frame_queue_empty", q.size(), 0);
    endtask

    initial begin
        fill_const(0, 0);
        repeat (3) @(negedge clk);
        outputs_zero("reset");
        n_rst = 1;
        repeat (2) @(negedge clk);

        fill_const(0, 1);
        wm[0][0] = 8'h37;
        chk("model_identity", model(1, 0), 'h37);
        run_frame(1, 1, 0, 1, 5, 7);

        fill_const(10, 1);
        chk("model_box", model(3, 3), 11);
        run_frame(3, 3, 3, 1, 0, 0);

        fill_const(255, 255);
        chk("model_sat", model(3, 0), 255);
        run_frame(3, 3, 0, 1, 2, 2);

        fill_pattern();
        chk("model_asym", model(2, 0), 127);
        run_frame(2, 2, 0, 1, 6, 1);
        run_frame(3, 3, 4, 4, 10, 20);
        run_frame(0, 1, 0, 1, 8, 9);

        fill_const(1, 1);
        chk("model_kmax", model(31, 2), 240);
        run_frame(40, 31, 2, 1, 2, 3);

        fill_pattern();
        kernel_size = 3; weight_shift = 2; kexp = 3; shv = 2;
        clr();
        start_frame();
        @(negedge clk);
        curr_x = 3; curr_y = 3; end_pos = 0;
        repeat (2) @(negedge clk);
        rdy_edge = cyc + 1;
        chk_lat = 1;
        new_sample_ready = 1;
        @(negedge clk);
        new_sample_ready = 0;
        while (cyc < rdy_edge + 6) @(negedge clk);
        #1;
        n_rst = 0;
        #1;
        outputs_zero("async_reset");
        q.delete();
        chk_lat = 0;
        repeat (3) @(negedge clk);
        n_rst = 1;
        repeat (30) @(negedge clk);
        chk("abandon_wen", n_wen, 0);
        chk("abandon_done", n_done, 0);
        chk("abandon_busy", int'(busy), 0);
        run_frame(3, 3, 2, 2, 0, 0);

        kernel_size = 2; weight_shift = 0; kexp = 2; shv = 0;
        clr();
        start_frame();
        @(negedge clk);
        curr_x = 1; curr_y = 1; end_pos = 0;
        new_sample_ready = 1;
        wait_for(0, 20, "robust_req");
        repeat (2) @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        wait_for(1, 100, "robust_update_pos");
        @(negedge clk);
        curr_x = 4; curr_y = 4; end_pos = 1;
        wait_for(2, 100, "robust_done");
        @(negedge clk);
        new_sample_ready = 0;
        end_pos = 0;
        repeat (5) @(negedge clk);
        chk("robust_new_trans", n_nt, 1);
        chk("robust_req", n_req, 2);
        chk("robust_wen", n_wen, 2);
        chk("robust_upd", n_upd, 1);
        chk("robust_done_cnt", n_done, 1);
        chk("robust_busy", int'(busy), 0);
        chk("robust_queue_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
